// File: rtl/maze_pkg.sv
// maze_pkg: maze coordinate type, default maze size and spawn FSM states shared by spawn logic
package maze_pkg;
  typedef logic [5:0] coord_t;
  localparam int MAZE_W = 40;
  localparam int MAZE_H = 20;
  typedef enum logic [2:0] {SEED, IDLE, DRAW, CHECK, WAIT, DONE} spawn_state_t;
  function automatic logic out_of_range(coord_t x, coord_t y, coord_t w, coord_t h);
    return x >= w || y >= h;
  endfunction
endpackage

// File: rtl/random_spawn_arbiter_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first requester at or after ptr
module rr_arbiter #(
  parameter int N = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx
);
  logic [IW:0]   sum;
  logic [IW-1:0] pos;
  // scan offsets high to low so the requester nearest ptr is the last one written
  always_comb begin
    grant = '0;
    idx = '0;
    sum = '0;
    pos = '0;
    for (int i = N - 1; i >= 0; i--) begin
      sum = {1'b0, ptr} + (IW+1)'(i);
      pos = sum >= (IW+1)'(N) ? IW'(sum - (IW+1)'(N)) : IW'(sum);
      if (req[pos]) begin
        grant = '0;
        grant[pos] = 1'b1;
        idx = pos;
      end
    end
  end
endmodule

// File: rtl/random_spawn_arbiter.sv
// random_spawn_arbiter: shares one coordinate generator among spawn requesters; SPAWN_DEDUP_EN also rejects already-used cells
module random_spawn_arbiter
  import maze_pkg::*;
#(
  parameter int          NUM_REQ   = 4,
  parameter int          SIZE_X    = MAZE_W,
  parameter int          SIZE_Y    = MAZE_H,
  parameter int          MAX_TRIES = 15,
  parameter logic [31:0] SEED      = 32'h1234_5678
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] grant,
  output logic               done,
  output logic [5:0]         coord_x,
  output logic [5:0]         coord_y,
  output logic               fail,
  output logic               rng_clk_en,
  output logic               rng_load,
  output logic [31:0]        rng_seed,
  input  logic [5:0]         rng_x,
  input  logic [5:0]         rng_y,
  output logic               wall_rd,
  output logic [5:0]         wall_x,
  output logic [5:0]         wall_y,
  input  logic               wall_hit
);
  localparam int         IW       = $clog2(NUM_REQ);
  localparam logic [5:0] LIM_X    = 6'(SIZE_X);
  localparam logic [5:0] LIM_Y    = 6'(SIZE_Y);
  localparam logic [5:0] TRY_LAST = 6'(MAX_TRIES - 1);
  spawn_state_t       state, state_nx;
  logic [NUM_REQ-1:0] grant_sel;
  logic [IW-1:0]      ptr, idx_sel, gidx;
  logic [5:0]         tries, draw_x, draw_y;
  logic               dup, reject, last;
  rr_arbiter #(.N(NUM_REQ), .IW(IW)) u_rr (
    .req(req),
    .ptr(ptr),
    .grant(grant_sel),
    .idx(idx_sel)
  );
  assign rng_seed = SEED;
  assign wall_x = rng_x;
  assign wall_y = rng_y;
  assign reject = wall_hit || out_of_range(draw_x, draw_y, LIM_X, LIM_Y) || dup;
  assign last = tries == TRY_LAST;
`ifdef SPAWN_DEDUP_EN
  logic [5:0]         ring_x [NUM_REQ];
  logic [5:0]         ring_y [NUM_REQ];
  logic [NUM_REQ-1:0] ring_v;
  logic [IW-1:0]      ring_wp;
  // a draw matching any stored placement is treated like a wall
  always_comb begin
    dup = 1'b0;
    for (int i = 0; i < NUM_REQ; i++)
      dup = dup | (ring_v[i] && ring_x[i] == draw_x && ring_y[i] == draw_y);
  end
  // record each successful placement, overwriting the oldest entry
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ring_v <= '0;
      ring_wp <= '0;
      for (int i = 0; i < NUM_REQ; i++) begin
        ring_x[i] <= '0;
        ring_y[i] <= '0;
      end
    end else if (state == DONE && !fail) begin
      ring_v[ring_wp] <= 1'b1;
      ring_x[ring_wp] <= coord_x;
      ring_y[ring_wp] <= coord_y;
      ring_wp <= ring_wp == IW'(NUM_REQ - 1) ? '0 : ring_wp + 1'b1;
    end
  end
`else
  assign dup = 1'b0;
`endif
  // sequence: seed once, then draw/check/judge per granted request
  always_comb begin
    state_nx = state;
    unique case (state)
      maze_pkg::SEED: state_nx = IDLE;
      IDLE:           state_nx = |req ? DRAW : IDLE;
      DRAW:           state_nx = CHECK;
      CHECK:          state_nx = WAIT;
      WAIT:           state_nx = reject && !last ? DRAW : DONE;
      DONE:           state_nx = IDLE;
      default:        state_nx = maze_pkg::SEED;
    endcase
  end
  // registered strobes aligned with the state they belong to, plus grant/pointer/draw bookkeeping
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= maze_pkg::SEED;
      grant <= '0;
      done <= 1'b0;
      fail <= 1'b0;
      coord_x <= '0;
      coord_y <= '0;
      rng_clk_en <= 1'b0;
      rng_load <= 1'b0;
      wall_rd <= 1'b0;
      ptr <= '0;
      gidx <= '0;
      tries <= '0;
      draw_x <= '0;
      draw_y <= '0;
    end else begin
      state <= state_nx;
      rng_clk_en <= state == maze_pkg::SEED || state_nx == DRAW;
      rng_load <= state == maze_pkg::SEED;
      wall_rd <= state_nx == CHECK;
      done <= state_nx == DONE;
      if (state == IDLE && |req) begin
        grant <= grant_sel;
        gidx <= idx_sel;
        tries <= '0;
      end
      if (state == CHECK) begin
        draw_x <= rng_x;
        draw_y <= rng_y;
      end
      if (state == WAIT && reject && !last) tries <= tries + 6'd1;
      if (state == WAIT && state_nx == DONE) begin
        fail <= reject;
        coord_x <= draw_x;
        coord_y <= draw_y;
      end
      if (state == DONE) begin
        grant <= '0;
        ptr <= gidx == IW'(NUM_REQ - 1) ? '0 : gidx + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_random_spawn_arbiter.sv
// tb_random_spawn_arbiter: scripted generator + model maze, table vectors and scoreboard of completions
module tb_random_spawn_arbiter;
  typedef struct {
    logic [3:0] req;
    int mode;
    int x0, y0, x1, y1;
    logic [3:0] g;
    int ex, ey;
    logic f;
    int lat, tries;
  } vec_t;
  typedef struct {
    logic [3:0] g;
    int x, y;
    logic f;
    int lat, tries;
  } exp_t;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic [3:0] req = '0;
  logic [3:0] grant;
  logic done, fail, rng_clk_en, rng_load, wall_rd, wall_hit;
  logic [5:0] coord_x, coord_y, rng_x, rng_y, wall_x, wall_y;
  logic [31:0] rng_seed;
  logic [5:0] gx [64];
  logic [5:0] gy [64];
  logic [5:0] gi;
  int maze_mode = 0;
  int total = 0;
  int bad = 0;
  int ndone = 0;
  exp_t sbq [$];
  exp_t m_e;
  bit in_svc = 0;
  logic [3:0] cur_g;
  int lat, tr;
  vec_t tv [7];

  random_spawn_arbiter dut (
    .clk(clk), .reset_n(reset_n), .req(req), .grant(grant), .done(done),
    .coord_x(coord_x), .coord_y(coord_y), .fail(fail),
    .rng_clk_en(rng_clk_en), .rng_load(rng_load), .rng_seed(rng_seed),
    .rng_x(rng_x), .rng_y(rng_y), .wall_rd(wall_rd), .wall_x(wall_x),
    .wall_y(wall_y), .wall_hit(wall_hit)
  );

  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  function automatic logic is_wall(input logic [5:0] x, input logic [5:0] y);
    return maze_mode == 1 || (maze_mode == 2 && !((x == 0 || x == 1) && y == 0));
  endfunction

  always @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      gi <= '0;
      rng_x <= '0;
      rng_y <= '0;
    end else if (rng_clk_en && !rng_load) begin
      rng_x <= gx[gi];
      rng_y <= gy[gi];
      gi <= gi + 6'd1;
    end else if (grant == 0) gi <= '0;

  always @(posedge clk or negedge reset_n)
    if (!reset_n) wall_hit <= 1'b0;
    else wall_hit <= wall_rd && is_wall(wall_x, wall_y);

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!reset_n) in_svc = 0;
    else begin
      if (grant != 0) begin
        check("grant_onehot", $countones(grant), 1);
        if (!in_svc) begin
          in_svc = 1;
          cur_g = grant;
          lat = 0;
          tr = 0;
        end else check("grant_hold", grant, cur_g);
        lat++;
        if (rng_clk_en) tr++;
      end
      if (done) begin
        if (sbq.size() == 0) check("unexpected_done", 1, 0);
        else begin
          m_e = sbq.pop_front();
          check("grant", grant, m_e.g);
          check("coord_x", coord_x, m_e.x);
          check("coord_y", coord_y, m_e.y);
          check("fail", fail, m_e.f);
          check("latency", lat, m_e.lat);
          check("draws", tr, m_e.tries);
        end
        in_svc = 0;
        ndone++;
      end
    end
  end

  task automatic fill(input int x0, input int y0, input int x1, input int y1);
    for (int i = 0; i < 64; i++) begin
      gx[i] = 6'(i == 0 ? x0 : x1);
      gy[i] = 6'(i == 0 ? y0 : y1);
    end
  endtask

  task automatic wait_dones(input int n);
    int target;
    int t;
    target = ndone + n;
    t = 0;
    while (ndone < target && t < 100 * n) begin
      @(negedge clk);
      #1;
      t++;
    end
    check("done_count", ndone - target + n, n);
  endtask

  task automatic wait_wall_rd();
    int t;
    t = 0;
    while (!wall_rd && t < 60) begin
      @(negedge clk);
      #1;
      t++;
    end
    check("wall_rd_seen", wall_rd, 1);
  endtask

  task automatic reset_cycle();
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_grant", grant, 0);
    check("rst_done", done, 0);
    check("rst_fail", fail, 0);
    check("rst_coord", {coord_x, coord_y}, 0);
    check("rst_rng_en", {rng_clk_en, rng_load}, 0);
    check("rst_wall_rd", wall_rd, 0);
    reset_n = 1'b1;
    @(negedge clk);
    #1;
    check("seed_load", {rng_clk_en, rng_load}, 3);
    check("seed_value", rng_seed, 32'h1234_5678);
    @(negedge clk);
    #1;
    check("seed_once", rng_load, 0);
  endtask

  task automatic serve(input logic [3:0] r, input exp_t e);
    sbq.push_back(e);
    req = r;
    wait_dones(1);
    req = '0;
    @(negedge clk);
    #1;
  endtask

  initial begin
    int quiet;
    exp_t ed [3];
    tv[0] = '{4'b0001, 0, 5, 7, 5, 7, 4'b0001, 5, 7, 1'b0, 4, 1};
    tv[1] = '{4'b0001, 0, 40, 3, 39, 19, 4'b0001, 39, 19, 1'b0, 7, 2};
    tv[2] = '{4'b0110, 0, 2, 20, 0, 0, 4'b0010, 0, 0, 1'b0, 7, 2};
    tv[3] = '{4'b1001, 0, 63, 63, 10, 10, 4'b1000, 10, 10, 1'b0, 7, 2};
    tv[4] = '{4'b1111, 1, 1, 1, 1, 1, 4'b0001, 1, 1, 1'b1, 46, 15};
    tv[5] = '{4'b0101, 0, 3, 4, 3, 4, 4'b0100, 3, 4, 1'b0, 4, 1};
    tv[6] = '{4'b0011, 0, 7, 8, 7, 8, 4'b0001, 7, 8, 1'b0, 4, 1};
    fill(0, 0, 0, 0);
    @(negedge clk);
    #1;
    reset_cycle();
    quiet = 0;
    repeat (5) begin
      @(negedge clk);
      #1;
      quiet += int'(grant != 0 || done);
    end
    check("idle_quiet", quiet, 0);
    for (int k = 0; k < 7; k++) begin
      maze_mode = tv[k].mode;
      fill(tv[k].x0, tv[k].y0, tv[k].x1, tv[k].y1);
      serve(tv[k].req, '{tv[k].g, tv[k].ex, tv[k].ey, tv[k].f, tv[k].lat, tv[k].tries});
    end
    reset_cycle();
    maze_mode = 0;
    fill(1, 1, 1, 1);
    for (int k = 0; k < 5; k++) sbq.push_back('{4'(1 << (k % 4)), 1, 1, 1'b0, 4, 1});
    req = 4'b1111;
    wait_dones(5);
    req = '0;
    @(negedge clk);
    #1;
    fill(4, 4, 4, 4);
    sbq.push_back('{4'b0001, 4, 4, 1'b0, 4, 1});
    req = 4'b0001;
    wait_wall_rd();
    req = '0;
    wait_dones(1);
    @(negedge clk);
    #1;
    req = 4'b0001;
    wait_wall_rd();
    @(negedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    check("midrst_grant", grant, 0);
    check("midrst_done_wall", {done, wall_rd, rng_clk_en}, 0);
    check("midrst_coord", coord_x, 0);
    req = '0;
    reset_cycle();
    maze_mode = 2;
    for (int i = 0; i < 64; i++) begin
      gx[i] = 6'(i % 2);
      gy[i] = '0;
    end
`ifdef SPAWN_DEDUP_EN
    ed[0] = '{4'b0001, 0, 0, 1'b0, 4, 1};
    ed[1] = '{4'b0010, 1, 0, 1'b0, 7, 2};
    ed[2] = '{4'b0100, 0, 0, 1'b1, 46, 15};
`else
    ed[0] = '{4'b0001, 0, 0, 1'b0, 4, 1};
    ed[1] = '{4'b0010, 0, 0, 1'b0, 4, 1};
    ed[2] = '{4'b0100, 0, 0, 1'b0, 4, 1};
`endif
    for (int k = 0; k < 3; k++) serve(ed[k].g, ed[k]);
    check("sb_empty", sbq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
